write_buffer: RTL
=================

WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of 128-bit entries (power of two, 2..16).
REQ-002 SHALL have parameter IDW, default 4, which SHALL equal log2(DEPTH).
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all logic on rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port xbar_wbuf_valid_i, input, 1 bit: fill request from xbar.
REQ-006 SHALL have port xbar_wbuf_ready_o, output, 1 bit: fill accepted.
REQ-007 SHALL have port xbar_wbuf_channel_id_i, input, 2 bits: owning channel of the fill.
REQ-008 SHALL have port xbar_wbuf_data_i, input, 128 bits: fill data.
REQ-009 SHALL have port wbuf_xbar_wbuffer_id_o, output, 8 bits: id allocated to the current fill, zero-extended from IDW.
REQ-010 SHALL have port rc_wbuf_req_valid_i, input, 1 bit: read request from sram_controller.
REQ-011 SHALL have port rc_wbuf_req_ready_o, output, 1 bit: read request accepted.
REQ-012 SHALL have port rc_wbuf_req_channel_id_i, input, 2 bits: requesting channel.
REQ-013 SHALL have port rc_wbuf_req_wbuffer_id_i, input, 8 bits: entry to read.
REQ-014 SHALL have port rc_wbuf_rtn_valid_o, output, 1 bit: return data valid.
REQ-015 SHALL have port rc_wbuf_rtn_ready_i, input, 1 bit: return data consumed.
REQ-016 SHALL have port rc_wbuf_rtn_data_o, output, 128 bits: return data.
REQ-017 SHALL have port wbuf_free_cnt_o, output, IDW+1 bits: free entry count.
REQ-018 SHALL have port wbuf_err_o, output, 1 bit: sticky protocol error.

Function
REQ-019 SHALL keep per entry the states FREE, FULL, BUSY (read accepted, return pending), plus a 2-bit owner channel and 128-bit data.
REQ-020 Fill: xbar_wbuf_ready_o SHALL be high iff at least one entry is FREE; wbuf_xbar_wbuffer_id_o SHALL be the lowest-index FREE entry.
REQ-021 Fill handshake (valid&ready) SHALL write data and owner, and move the entry FREE->FULL on the same edge.
REQ-022 Read: rc_wbuf_req_ready_o SHALL be high iff the addressed entry is FULL and the return register is empty or being drained in this cycle (rtn_valid & rtn_ready).
REQ-023 A request with wbuffer_id[7:IDW] nonzero SHALL be accepted as soon as return register space allows, SHALL return all-zero data, and SHALL set wbuf_err_o.
REQ-024 Read handshake SHALL load the entry data into the return register and assert rc_wbuf_rtn_valid_o on the next cycle (latency 1), and SHALL move the entry FULL->BUSY.
REQ-025 rc_wbuf_rtn_valid_o and rc_wbuf_rtn_data_o SHALL hold stable until rc_wbuf_rtn_ready_i is high.
REQ-026 Return handshake SHALL move the BUSY entry ->FREE; that entry SHALL NOT be allocatable until the following cycle.
REQ-027 Return and new read handshakes in the same cycle SHALL give back-to-back valid returns with no bubble.
REQ-028 A request to a FREE or BUSY entry SHALL be held off (ready low) until the entry becomes FULL; there SHALL be no combinational path from rc_wbuf_req_valid_i to xbar_wbuf_ready_o.
REQ-029 A request whose channel id differs from the entry owner SHALL still be served, and SHALL set wbuf_err_o.
REQ-030 wbuf_free_cnt_o SHALL equal the number of FREE entries after each edge, with +1 per return handshake and -1 per fill handshake; a simultaneous return and fill SHALL net to zero.
REQ-031 Full state: free count 0 SHALL drive xbar_wbuf_ready_o low; empty state SHALL give count DEPTH.

Reset
REQ-032 On rst_i high at an edge, all entries SHALL become FREE, the return register SHALL become empty, and wbuf_err_o SHALL become 0, regardless of any operation in progress.
REQ-033 While and after reset, the outputs SHALL be: rc_wbuf_rtn_valid_o=0, rc_wbuf_rtn_data_o=0, wbuf_free_cnt_o=DEPTH, xbar_wbuf_ready_o=1, wbuf_xbar_wbuffer_id_o=0.
REQ-034 Data storage SHALL need no reset.

Structure
REQ-035 The entry-state encoding (FREE/FULL/BUSY) and the default DEPTH SHALL live in the shared cache package.
REQ-036 SHALL have one sub-module, wbuf_alloc, a lowest-index free-entry priority encoder.

Verification
REQ-037 After reset, fill 0xA5..A5 on channel 2 -> id 0; count 16->15.
REQ-038 Read id 0, channel 2, with rtn_ready=1 -> rtn_valid one cycle later with data 0xA5..A5; count 15->16.
REQ-039 Fill 16 entries -> xbar_wbuf_ready_o=0, count 0; one read plus return -> ready=1 the cycle after and id = freed index.
REQ-040 Hold rtn_ready=0 for 5 cycles with a second request pending -> data stable, req_ready=0; release -> back-to-back returns.
REQ-041 Read id 3 while FREE -> held off; fill id 3 -> accepted the next cycle.
REQ-042 Channel mismatch, or id 0x20 -> wbuf_err_o=1 and sticky; assert rst_i during a pending return -> rtn_valid=0, count=16.

Source files
------------

// File: rtl/write_buffer_pkg.sv
// Shared cache package: write-buffer entry states, default geometry and bus widths.
package write_buffer_pkg;

    localparam int WBUF_DEFAULT_DEPTH = 16;
    localparam int WBUF_DATA_W        = 128;
    localparam int WBUF_ID_W          = 8;
    localparam int WBUF_CH_W          = 2;

    localparam logic [1:0] ENT_FREE = 2'd0;
    localparam logic [1:0] ENT_FULL = 2'd1;
    localparam logic [1:0] ENT_BUSY = 2'd2;

endpackage

// File: rtl/write_buffer_if.sv
// Fill (xbar) and read/return (sram_controller) handshakes of the write buffer.
interface write_buffer_if;
    import write_buffer_pkg::*;

    logic                   xbar_wbuf_valid_i;
    logic                   xbar_wbuf_ready_o;
    logic [WBUF_CH_W-1:0]   xbar_wbuf_channel_id_i;
    logic [WBUF_DATA_W-1:0] xbar_wbuf_data_i;
    logic [WBUF_ID_W-1:0]   wbuf_xbar_wbuffer_id_o;

    logic                   rc_wbuf_req_valid_i;
    logic                   rc_wbuf_req_ready_o;
    logic [WBUF_CH_W-1:0]   rc_wbuf_req_channel_id_i;
    logic [WBUF_ID_W-1:0]   rc_wbuf_req_wbuffer_id_i;

    logic                   rc_wbuf_rtn_valid_o;
    logic                   rc_wbuf_rtn_ready_i;
    logic [WBUF_DATA_W-1:0] rc_wbuf_rtn_data_o;

    modport master (
        output xbar_wbuf_valid_i, xbar_wbuf_channel_id_i, xbar_wbuf_data_i,
        input  xbar_wbuf_ready_o, wbuf_xbar_wbuffer_id_o,
        output rc_wbuf_req_valid_i, rc_wbuf_req_channel_id_i, rc_wbuf_req_wbuffer_id_i,
        input  rc_wbuf_req_ready_o,
        input  rc_wbuf_rtn_valid_o, rc_wbuf_rtn_data_o,
        output rc_wbuf_rtn_ready_i
    );

    modport slave (
        input  xbar_wbuf_valid_i, xbar_wbuf_channel_id_i, xbar_wbuf_data_i,
        output xbar_wbuf_ready_o, wbuf_xbar_wbuffer_id_o,
        input  rc_wbuf_req_valid_i, rc_wbuf_req_channel_id_i, rc_wbuf_req_wbuffer_id_i,
        output rc_wbuf_req_ready_o,
        output rc_wbuf_rtn_valid_o, rc_wbuf_rtn_data_o,
        input  rc_wbuf_rtn_ready_i
    );

endinterface

// File: rtl/write_buffer_alloc.sv
// Lowest-index free-entry priority encoder used for fill allocation.
module wbuf_alloc #(
    parameter int N   = 16,
    parameter int IDW = 4
) (
    input  logic [N-1:0]   free_vec,
    output logic           found,
    output logic [IDW-1:0] idx
);

    // Scan from the top down so the lowest free index is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                found = 1'b1;
                idx   = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/write_buffer.sv
// Write buffer: xbar fills free entries, sram_controller reads them back
// through a single-entry return register; an entry is freed when its return
// data is consumed.
//
// Entry state table:
//   state    | meaning
//   ENT_FREE | allocatable by the next fill
//   ENT_FULL | holds fill data, readable
//   ENT_BUSY | read accepted, return data not yet consumed
module write_buffer
    import write_buffer_pkg::*;
#(
    parameter int DEPTH = WBUF_DEFAULT_DEPTH,
    parameter int IDW   = $clog2(DEPTH)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    write_buffer_if.slave  bus,
    output logic [IDW:0]   wbuf_free_cnt_o,
    output logic           wbuf_err_o
);

    localparam logic [IDW:0] CNT_DEPTH = (IDW + 1)'(DEPTH);

    logic [1:0]             ent_state [DEPTH];
    logic [WBUF_CH_W-1:0]   ent_owner [DEPTH];
    logic [WBUF_DATA_W-1:0] ent_data  [DEPTH];

    logic [DEPTH-1:0]       free_vec;
    logic                   alloc_found;
    logic [IDW-1:0]         alloc_idx;

    logic                   rtn_valid;
    logic [WBUF_DATA_W-1:0] rtn_data;
    logic [IDW-1:0]         rtn_idx;
    logic                   rtn_is_entry;

    logic                   req_oob;
    logic [IDW-1:0]         req_idx;
    logic                   rtn_space;
    logic                   req_ready;
    logic                   fill_hs;
    logic                   rd_hs;
    logic                   rtn_hs;
    logic                   rtn_frees;
    logic [WBUF_DATA_W-1:0] rd_data_sel;
    logic                   rd_err;

    // Free-entry map feeding the allocator.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            free_vec[i] = (ent_state[i] == ENT_FREE);
        end
    end

    wbuf_alloc #(.N(DEPTH), .IDW(IDW)) u_alloc (
        .free_vec (free_vec),
        .found    (alloc_found),
        .idx      (alloc_idx)
    );

    // Handshake decode; fill readiness depends on entry state only, never on the read request.
    always_comb begin
        req_idx     = bus.rc_wbuf_req_wbuffer_id_i[IDW-1:0];
        req_oob     = |bus.rc_wbuf_req_wbuffer_id_i[WBUF_ID_W-1:IDW];
        rtn_hs      = rtn_valid && bus.rc_wbuf_rtn_ready_i;
        rtn_space   = !rtn_valid || bus.rc_wbuf_rtn_ready_i;
        req_ready   = rtn_space && (req_oob || (ent_state[req_idx] == ENT_FULL));
        fill_hs     = bus.xbar_wbuf_valid_i && alloc_found;
        rd_hs       = bus.rc_wbuf_req_valid_i && req_ready;
        rtn_frees   = rtn_hs && rtn_is_entry;
        rd_data_sel = req_oob ? '0 : ent_data[req_idx];
        rd_err      = req_oob || (ent_owner[req_idx] != bus.rc_wbuf_req_channel_id_i);
    end

    assign bus.xbar_wbuf_ready_o      = alloc_found;
    assign bus.wbuf_xbar_wbuffer_id_o = WBUF_ID_W'(alloc_idx);
    assign bus.rc_wbuf_req_ready_o    = req_ready;
    assign bus.rc_wbuf_rtn_valid_o    = rtn_valid;
    assign bus.rc_wbuf_rtn_data_o     = rtn_data;

    // Entry state transitions; fill, read and return always hit distinct entries.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_state[i] <= ENT_FREE;
            end
        end else begin
            if (fill_hs) begin
                ent_state[alloc_idx] <= ENT_FULL;
            end
            if (rd_hs && !req_oob) begin
                ent_state[req_idx] <= ENT_BUSY;
            end
            if (rtn_frees) begin
                ent_state[rtn_idx] <= ENT_FREE;
            end
        end
    end

    // Entry payload capture on fill; storage is not reset.
    always_ff @(posedge clk_i) begin
        if (fill_hs) begin
            ent_data[alloc_idx]  <= bus.xbar_wbuf_data_i;
            ent_owner[alloc_idx] <= bus.xbar_wbuf_channel_id_i;
        end
    end

    // Return register: load on read, hold until consumed, reload in the same cycle for back-to-back returns.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rtn_valid    <= 1'b0;
            rtn_data     <= '0;
            rtn_idx      <= '0;
            rtn_is_entry <= 1'b0;
        end else if (rd_hs) begin
            rtn_valid    <= 1'b1;
            rtn_data     <= rd_data_sel;
            rtn_idx      <= req_idx;
            rtn_is_entry <= !req_oob;
        end else if (rtn_hs) begin
            rtn_valid    <= 1'b0;
        end
    end

    // Free-entry counter: +1 per freeing return, -1 per fill.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wbuf_free_cnt_o <= CNT_DEPTH;
        end else begin
            case ({rtn_frees, fill_hs})
                2'b10:   wbuf_free_cnt_o <= wbuf_free_cnt_o + 1'b1;
                2'b01:   wbuf_free_cnt_o <= wbuf_free_cnt_o - 1'b1;
                default: wbuf_free_cnt_o <= wbuf_free_cnt_o;
            endcase
        end
    end

    // Sticky protocol error on out-of-range id or channel/owner mismatch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wbuf_err_o <= 1'b0;
        end else if (rd_hs && rd_err) begin
            wbuf_err_o <= 1'b1;
        end
    end

endmodule
